produto_escalar_ctrl: RTL

Front-end controller for the `produto_escalar` dot-product engine. It shares one engine between two requesters, with round-robin arbitration. Each requester streams 8 operand pairs over a valid/ready handshake. The controller holds the pairs in an operand bank that drives the engine inputs, pulses `start`, and waits for `done` with a timeout. It returns the 64-bit signed result tagged with the requester ID on a valid/ready result port.

---
 rtl/produto_escalar_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/produto_escalar_ctrl.sv
// produto_escalar_ctrl
// Front-end controller that shares one dot-product engine between two
// requesters. A round-robin arbiter picks a requester, its eight operand
// pairs are collected into an operand bank wired to the engine, the engine
// is started once, and its result (or a timeout error) is returned on a
// valid/ready result port tagged with the owner's ID.
module produto_escalar_ctrl #(
  parameter int N_ELEM  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r0_valid,
  input  logic [31:0]              r0_a,
  input  logic [31:0]              r0_b,
  output logic                     r0_ready,
  input  logic                     r1_valid,
  input  logic [31:0]              r1_a,
  input  logic [31:0]              r1_b,
  output logic                     r1_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [63:0]              res_data,
  output logic                     res_id,
  output logic                     res_err,
  output logic [32*N_ELEM-1:0]     eng_a,
  output logic [32*N_ELEM-1:0]     eng_b,
  output logic                     eng_start,
  input  logic                     eng_done,
  input  logic [63:0]              eng_result,
  output logic                     busy
);

  localparam int CW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     lastGrant_q, lastGrant_d;
  logic [CW-1:0]            beat_q, beat_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [63:0]              resData_q, resData_d;
  logic                     resErr_q, resErr_d;
  logic [N_ELEM-1:0][31:0]  bankA_q, bankA_d;
  logic [N_ELEM-1:0][31:0]  bankB_q, bankB_d;

  logic                     selValid;
  logic [31:0]              selA;
  logic [31:0]              selB;
  logic                     beatFire;

  // Route the granted requester's beat towards the operand bank.
  always_comb begin
    selValid = grant_q ? r1_valid : r0_valid;
    selA     = grant_q ? r1_a : r0_a;
    selB     = grant_q ? r1_b : r0_b;
    beatFire = (state_q == ST_LOAD) && selValid;
  end

  // Next-state logic: arbitration, operand collection, engine handshake,
  // timeout supervision and result hand-off.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    resData_d   = resData_q;
    resErr_d    = resErr_q;
    bankA_d     = bankA_q;
    bankB_d     = bankB_q;
    case (state_q)
      ST_IDLE: begin
        if (r0_valid || r1_valid) begin
          // On a tie the requester that was not served last time wins.
          if (r0_valid && r1_valid) grant_d = ~lastGrant_q;
          else                      grant_d = r1_valid;
          beat_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (beatFire) begin
          bankA_d[beat_q] = selA;
          bankB_d[beat_q] = selB;
          beat_d          = beat_q + CW'(1);
          if (beat_q == CW'(N_ELEM - 1)) state_d = ST_START;
        end
      end
      ST_START: begin
        // A done still high from the previous run must clear before starting.
        if (!eng_done) begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (eng_done) begin
          resData_d = eng_result;
          resErr_d  = 1'b0;
          state_d   = ST_RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          resData_d = '0;
          resErr_d  = 1'b1;
          state_d   = ST_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          lastGrant_d = grant_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      beat_q      <= '0;
      tmo_q       <= '0;
      resData_q   <= '0;
      resErr_q    <= 1'b0;
      bankA_q     <= '0;
      bankB_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      resData_q   <= resData_d;
      resErr_q    <= resErr_d;
      bankA_q     <= bankA_d;
      bankB_q     <= bankB_d;
    end
  end

  // Outputs decoded from the registered state so reset clears them at once.
  always_comb begin
    r0_ready  = (state_q == ST_LOAD) && !grant_q;
    r1_ready  = (state_q == ST_LOAD) &&  grant_q;
    eng_start = (state_q == ST_START) && !eng_done;
    res_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE);
    res_data  = resData_q;
    res_err   = resErr_q;
    res_id    = grant_q;
    eng_a     = bankA_q;
    eng_b     = bankB_q;
  end

endmodule
